// File: rtl/pwm_ctrl_pkg.sv
// Shared definitions for the PWM ramp controller.
//   DefDw   : default duty word width, matches the PWM block's duty input.
//   state_e : sequencer states (idle, ramping, dead-time, emergency stop).
package pwm_ctrl_pkg;

  localparam int unsigned DefDw = 4;

  typedef enum logic [1:0] {
    StIdle,
    StRamp,
    StDead,
    StEstop
  } state_e;

endpackage

// File: rtl/pwm_tick_div.sv
// Period-tick prescaler for the duty ramp.
//   CLK    : system clock, rising edge
//   RST    : synchronous active-high reset
//   clear  : hold the count at zero (asserted whenever not ramping)
//   tick   : one-cycle PWM period pulse
//   strobe : pulses on every RAMP_DIV-th tick after the count leaves clear
module pwm_tick_div #(
  parameter int unsigned RAMP_DIV = 4
) (
  input  logic CLK,
  input  logic RST,
  input  logic clear,
  input  logic tick,
  output logic strobe
);

  localparam int unsigned CW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic [CW-1:0] Last = CW'(RAMP_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign strobe = tick && !clear && (cnt_q == Last);

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (tick) begin
      cnt_d = (cnt_q == Last) ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/pwm_ramp_ctrl.sv
// Speed/direction sequencer for the motor PWM generator.
// Slews duty_out toward the commanded duty on ramp strobes; reversals ramp to zero,
// disable the bridge for a dead time, flip direction, then ramp back up.
//   CLK, RST          : clock and synchronous active-high reset
//   period_tick       : one-cycle pulse at each PWM period start
//   cmd_valid/ready   : command handshake; cmd_duty/cmd_dir are the new target
//   estop             : level-sensitive emergency stop
//   duty_out, dir_out : duty word and H-bridge direction
//   enable_out        : H-bridge enable
//   at_target, busy   : settled at the target / not settled
module pwm_ramp_ctrl
  import pwm_ctrl_pkg::*;
#(
  parameter int unsigned DW         = DefDw,
  parameter int unsigned STEP       = 1,
  parameter int unsigned RAMP_DIV   = 4,
  parameter int unsigned DEAD_TICKS = 2
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          period_tick,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [DW-1:0] cmd_duty,
  input  logic          cmd_dir,
  input  logic          estop,
  output logic [DW-1:0] duty_out,
  output logic          dir_out,
  output logic          enable_out,
  output logic          at_target,
  output logic          busy
);

  localparam int unsigned DCW = $clog2(DEAD_TICKS + 1);
  localparam logic [DW-1:0]  StepD    = DW'(STEP);
  localparam logic [DCW-1:0] DeadLoad = DCW'(DEAD_TICKS);

  state_e         state_q, state_d;
  logic [DW-1:0]  duty_q, duty_d, tgt_duty_q, tgt_duty_d, eff;
  logic           dir_q, dir_d, en_q, en_d, tgt_dir_q, tgt_dir_d;
  logic [DCW-1:0] dead_q, dead_d;
  logic           dir_mismatch, strobe;

  // Move cur toward tgt by StepD, landing exactly on tgt rather than overshooting.
  function automatic logic [DW-1:0] step_toward(logic [DW-1:0] cur, logic [DW-1:0] tgt);
    if (cur < tgt) begin
      return ((tgt - cur) <= StepD) ? tgt : cur + StepD;
    end else begin
      return ((cur - tgt) <= StepD) ? tgt : cur - StepD;
    end
  endfunction

  pwm_tick_div #(
    .RAMP_DIV(RAMP_DIV)
  ) u_div (
    .CLK   (CLK),
    .RST   (RST),
    .clear (state_q != StRamp),
    .tick  (period_tick && !estop),
    .strobe(strobe)
  );

  assign dir_mismatch = (tgt_dir_q != dir_q);
  // A pending reversal ramps to zero first.
  assign eff          = dir_mismatch ? '0 : tgt_duty_q;

  assign cmd_ready  = (state_q != StEstop);
  assign duty_out   = duty_q;
  assign dir_out    = dir_q;
  assign enable_out = en_q;
  assign at_target  = (state_q == StIdle) && (duty_q == tgt_duty_q) && !dir_mismatch;
  assign busy       = !at_target;

  always_comb begin
    state_d    = state_q;
    duty_d     = duty_q;
    dir_d      = dir_q;
    en_d       = en_q;
    tgt_duty_d = tgt_duty_q;
    tgt_dir_d  = tgt_dir_q;
    dead_d     = dead_q;

    if (estop) begin
      // Any command presented on the entry cycle is dropped.
      state_d    = StEstop;
      duty_d     = '0;
      en_d       = 1'b0;
      tgt_duty_d = '0;
    end else begin
      if (cmd_valid && cmd_ready) begin
        tgt_duty_d = cmd_duty;
        tgt_dir_d  = cmd_dir;
      end
      unique case (state_q)
        StIdle: begin
          if (duty_q != eff) begin
            state_d = StRamp;
          end else if (dir_mismatch) begin
            state_d = StDead;
            en_d    = 1'b0;
            dead_d  = DeadLoad;
          end
        end
        StRamp: begin
          if (duty_q == eff) begin
            if (dir_mismatch) begin
              state_d = StDead;
              en_d    = 1'b0;
              dead_d  = DeadLoad;
            end else begin
              state_d = StIdle;
            end
          end else if (strobe) begin
            duty_d = step_toward(duty_q, eff);
          end
        end
        StDead: begin
          if (period_tick) begin
            if (dead_q <= DCW'(1)) begin
              dir_d   = tgt_dir_q;
              en_d    = 1'b1;
              dead_d  = '0;
              state_d = StIdle;
            end else begin
              dead_d = dead_q - 1'b1;
            end
          end
        end
        StEstop: begin
          state_d = StDead;
          en_d    = 1'b0;
          dead_d  = DeadLoad;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= StIdle;
      duty_q     <= '0;
      dir_q      <= 1'b0;
      en_q       <= 1'b1;
      tgt_duty_q <= '0;
      tgt_dir_q  <= 1'b0;
      dead_q     <= '0;
    end else begin
      state_q    <= state_d;
      duty_q     <= duty_d;
      dir_q      <= dir_d;
      en_q       <= en_d;
      tgt_duty_q <= tgt_duty_d;
      tgt_dir_q  <= tgt_dir_d;
      dead_q     <= dead_d;
    end
  end

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Directed bench for pwm_ramp_ctrl. Expected outputs are queued as stimulus is driven
// and popped when the outputs are sampled. A second instance runs with STEP=4.
module tb_pwm_ramp_ctrl;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       period_tick = 1'b0;
  logic       estop = 1'b0;
  logic       cmd_valid = 1'b0;
  logic [3:0] cmd_duty = '0;
  logic       cmd_dir = 1'b0;
  logic       cmd_ready, dir_out, enable_out, at_target, busy;
  logic [3:0] duty_out;

  logic       cmd_valid5 = 1'b0;
  logic [3:0] cmd_duty5 = '0;
  logic       cmd_ready5, dir_out5, enable_out5, at_target5, busy5;
  logic [3:0] duty_out5;

  always #5 CLK = ~CLK;

  pwm_ramp_ctrl #(
    .DW(4), .STEP(1), .RAMP_DIV(4), .DEAD_TICKS(2)
  ) u_dut (
    .CLK(CLK), .RST(RST), .period_tick(period_tick), .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready), .cmd_duty(cmd_duty), .cmd_dir(cmd_dir), .estop(estop),
    .duty_out(duty_out), .dir_out(dir_out), .enable_out(enable_out),
    .at_target(at_target), .busy(busy)
  );

  pwm_ramp_ctrl #(
    .DW(4), .STEP(4), .RAMP_DIV(4), .DEAD_TICKS(2)
  ) u_dut5 (
    .CLK(CLK), .RST(RST), .period_tick(period_tick), .cmd_valid(cmd_valid5),
    .cmd_ready(cmd_ready5), .cmd_duty(cmd_duty5), .cmd_dir(1'b0), .estop(estop),
    .duty_out(duty_out5), .dir_out(dir_out5), .enable_out(enable_out5),
    .at_target(at_target5), .busy(busy5)
  );

  typedef struct {
    string      tag;
    logic [3:0] duty;
    logic       dir;
    logic       en;
    logic       rdy;
    logic       at;
  } exp_t;

  exp_t sb[$];
  exp_t sb5[$];
  int unsigned n_vec = 0;
  int unsigned n_bad = 0;
  logic [3:0]  m_tgt = '0;
  logic        m_tdir = 1'b0;
  logic [3:0]  m_tgt5 = '0;

  function automatic logic [3:0] mv(int start, int eff, int delta);
    if (start < eff) return 4'((start + delta > eff) ? eff : start + delta);
    return 4'((start - delta < eff) ? eff : start - delta);
  endfunction

  task automatic push(string tag, logic [3:0] duty, logic dir, logic en, logic rdy);
    exp_t e;
    e.tag = tag; e.duty = duty; e.dir = dir; e.en = en; e.rdy = rdy;
    e.at  = en && rdy && (duty == m_tgt) && (dir == m_tdir);
    sb.push_back(e);
  endtask

  task automatic push5(string tag, logic [3:0] duty);
    exp_t e;
    e.tag = tag; e.duty = duty; e.dir = 1'b0; e.en = 1'b1; e.rdy = 1'b1;
    e.at  = (duty == m_tgt5);
    sb5.push_back(e);
  endtask

  task automatic check();
    exp_t e;
    e = sb.pop_front();
    n_vec++;
    assert (duty_out === e.duty && dir_out === e.dir && enable_out === e.en &&
            cmd_ready === e.rdy && at_target === e.at && busy === !e.at)
    else begin
      n_bad++;
      $error("FAIL %s: got duty=%0d dir=%b en=%b rdy=%b at=%b busy=%b; want duty=%0d dir=%b en=%b rdy=%b at=%b",
             e.tag, duty_out, dir_out, enable_out, cmd_ready, at_target, busy,
             e.duty, e.dir, e.en, e.rdy, e.at);
    end
  endtask

  task automatic check5();
    exp_t e;
    e = sb5.pop_front();
    n_vec++;
    assert (duty_out5 === e.duty && dir_out5 === e.dir && enable_out5 === e.en &&
            cmd_ready5 === e.rdy && at_target5 === e.at && busy5 === !e.at)
    else begin
      n_bad++;
      $error("FAIL %s: got duty=%0d dir=%b en=%b rdy=%b at=%b busy=%b; want duty=%0d at=%b",
             e.tag, duty_out5, dir_out5, enable_out5, cmd_ready5, at_target5, busy5,
             e.duty, e.at);
    end
  endtask

  // One PWM period of 16 clocks, tick on the first.
  task automatic tick_period();
    period_tick = 1'b1;
    @(negedge CLK);
    period_tick = 1'b0;
    repeat (15) @(negedge CLK);
  endtask

  task automatic send_cmd(logic [3:0] d, logic dir);
    cmd_valid = 1'b1; cmd_duty = d; cmd_dir = dir;
    @(negedge CLK);
    cmd_valid = 1'b0;
    m_tgt = d; m_tdir = dir;
    repeat (2) @(negedge CLK);
  endtask

  initial begin
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    push("reset", 4'd0, 1'b0, 1'b1, 1'b1);
    check();
    push5("reset5", 4'd0);
    check5();

    // Ramp 0 -> 5 (STEP 1) and 0 -> 15 (STEP 4) in parallel.
    cmd_valid5 = 1'b1; cmd_duty5 = 4'd15;
    m_tgt5 = 4'd15;
    send_cmd(4'd5, 1'b0);
    cmd_valid5 = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      push("t1_up", mv(0, 5, n / 4), 1'b0, 1'b1, 1'b1);
      push5("t5_step4", mv(0, 15, 4 * (n / 4)));
      tick_period();
      check();
      check5();
    end

    // Ramp down 5 -> 2, then a repeated identical command.
    send_cmd(4'd2, 1'b0);
    for (int n = 1; n <= 12; n++) begin
      push("t2_down", mv(5, 2, n / 4), 1'b0, 1'b1, 1'b1);
      tick_period();
      check();
    end
    send_cmd(4'd2, 1'b0);
    push("t2_same", 4'd2, 1'b0, 1'b1, 1'b1);
    check();

    // Reversal from duty 3 dir 0 to duty 2 dir 1.
    send_cmd(4'd3, 1'b0);
    for (int n = 1; n <= 4; n++) begin
      push("t3_pre", mv(2, 3, n / 4), 1'b0, 1'b1, 1'b1);
      tick_period();
      check();
    end
    send_cmd(4'd2, 1'b1);
    for (int n = 1; n <= 12; n++) begin
      push("t3_rdown", mv(3, 0, n / 4), 1'b0, (n != 12), 1'b1);
      tick_period();
      check();
    end
    push("t3_dead", 4'd0, 1'b0, 1'b0, 1'b1);
    tick_period();
    check();
    push("t3_flip", 4'd0, 1'b1, 1'b1, 1'b1);
    tick_period();
    check();
    for (int n = 1; n <= 8; n++) begin
      push("t3_rup", mv(0, 2, n / 4), 1'b1, 1'b1, 1'b1);
      tick_period();
      check();
    end

    // Estop mid-ramp at duty 3, with a simultaneous command that must be dropped.
    send_cmd(4'd5, 1'b1);
    for (int n = 1; n <= 4; n++) begin
      push("t4_up", mv(2, 5, n / 4), 1'b1, 1'b1, 1'b1);
      tick_period();
      check();
    end
    estop = 1'b1; cmd_valid = 1'b1; cmd_duty = 4'd9; cmd_dir = 1'b0;
    @(negedge CLK);
    m_tgt = 4'd0;
    push("t4_estop", 4'd0, 1'b1, 1'b0, 1'b0);
    check();
    tick_period();
    tick_period();
    push("t4_hold", 4'd0, 1'b1, 1'b0, 1'b0);
    check();
    cmd_valid = 1'b0;
    estop = 1'b0;
    @(negedge CLK);
    push("t4_rel", 4'd0, 1'b1, 1'b0, 1'b1);
    check();
    push("t4_dead1", 4'd0, 1'b1, 1'b0, 1'b1);
    tick_period();
    check();
    push("t4_dead2", 4'd0, 1'b1, 1'b1, 1'b1);
    tick_period();
    check();

    // Reset while in the dead time.
    send_cmd(4'd0, 1'b0);
    push("t6_dead", 4'd0, 1'b1, 1'b0, 1'b1);
    check();
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    m_tgt = 4'd0; m_tdir = 1'b0; m_tgt5 = 4'd0;
    push("t6_rst", 4'd0, 1'b0, 1'b1, 1'b1);
    check();
    push5("t6_rst5", 4'd0);
    check5();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/pwm_ramp_ctrl.md
Name: pwm_ramp_ctrl

Overview:
Speed/direction sequencer for the motor PWM generator. It accepts target duty and direction commands over a valid/ready handshake and slews the PWM duty word toward the target in fixed steps, synchronised to PWM period boundaries. Direction reversals are sequenced as ramp-down to zero, then a dead-time with the bridge disabled, then a direction flip and ramp-up. Sits between the command source (host/UART decoder) and the PWM block's duty input.

Parameters:
DW, 4, duty word width; matches the PWM block's duty input.
STEP, 1, duty change per ramp strobe; 1..2^DW-1.
RAMP_DIV, 4, PWM periods per ramp strobe; >=1.
DEAD_TICKS, 2, PWM periods with enable_out low during reversal or after estop; >=1.

Ports:
CLK  in  1  system clock; all logic is rising-edge.
RST  in  1  synchronous, active-high reset.
period_tick  in  1  one-CLK pulse from the PWM block at each period start.
cmd_valid  in  1  command present.
cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
cmd_duty  in  DW  target duty.
cmd_dir  in  1  target direction.
estop  in  1  level-sensitive emergency stop.
duty_out  out  DW  duty word to the PWM block.
dir_out  out  1  H-bridge direction.
enable_out  out  1  H-bridge enable.
at_target  out  1  state==IDLE && duty_out==tgt_duty && dir_out==tgt_dir.
busy  out  1  equals !at_target.

Behaviour:
- Reset values: duty_out=0, dir_out=0, enable_out=1, tgt_duty=0, tgt_dir=0, state=IDLE, counters=0, cmd_ready=1.
- States: IDLE, RAMP, DEAD, ESTOP.
- cmd_ready=1 in IDLE, RAMP and DEAD; 0 in ESTOP. An accepted command overwrites tgt_duty/tgt_dir in the same edge. Retargeting mid-ramp is legal, and the ramp divider is not reset.
- Effective target: eff = (tgt_dir != dir_out) ? 0 : tgt_duty.
- IDLE -> RAMP on the edge after duty_out != eff. IDLE -> DEAD when duty_out==0 and tgt_dir != dir_out.
- Ramp divider: cleared on entry to RAMP. It increments on each period_tick. A strobe fires on the tick where the count reaches RAMP_DIV-1, and the count then wraps to 0. So the first step lands on the RAMP_DIV-th tick after entry.
- On a strobe, duty_out moves toward eff by STEP, clamped to eff with no overshoot. duty_out therefore changes only in a period_tick cycle, never mid-period.
- RAMP exits when duty_out==eff. It goes to DEAD if tgt_dir != dir_out, otherwise to IDLE.
- DEAD: enable_out=0 on the entry edge, and the dead counter is loaded with DEAD_TICKS and decremented on each period_tick. When it reaches 0: dir_out<=tgt_dir and enable_out<=1 in the same edge, then go to IDLE, which re-evaluates and ramps up.
- A new command during DEAD updates the target. The dead time is never shortened.
- ESTOP: entered from any state on the first edge with estop=1 (highest priority). Same edge: duty_out=0, enable_out=0, tgt_duty=0. dir_out and tgt_dir are unchanged.
- ESTOP is held while estop=1. On release, go to DEAD with the counter reloaded, then to IDLE with duty 0.
- Simultaneous estop and cmd_valid: estop wins and the command is not accepted (cmd_ready is already 0 from that edge onward; in the entry cycle the command is dropped).
- period_tick while estop=1 is ignored.
- RST mid-operation returns to reset values at the next edge, regardless of state.

Decomposition:
- Shared package pwm_ctrl_pkg: state encoding (IDLE, RAMP, DEAD, ESTOP) and default DW=4.
- One sub-module, pwm_tick_div: a period_tick prescaler with clear input and strobe output, parameterised by RAMP_DIV. The dead counter stays inline.

Test Plan:
1. After reset, cmd (duty=5, dir=0), period_tick every 16 CLK -> duty_out steps 1,2,3,4,5 on ticks 4,8,12,16,20; at_target=1 after tick 20; enable_out stays 1.
2. From duty 5, cmd duty=2 -> duty_out 4,3,2 on ticks 4,8,12, then IDLE; cmd duty=2 again -> no change, at_target remains 1.
3. Reversal: duty 3 dir 0, cmd (2,1) -> duty 2,1,0 over 12 ticks; enable_out=0 for 2 ticks; dir_out=1 and enable_out=1 together; duty 1,2 over 8 ticks.
4. Mid-ramp estop at duty 3 -> next edge duty_out=0, enable_out=0, cmd_ready=0; release -> enable_out=1 after 2 ticks, duty stays 0, at_target=1.
5. STEP=4, DW=4, 0 -> cmd 15 -> duty_out 4,8,12,15 (clamped), no overshoot.
6. RST asserted while in DEAD -> next edge: enable_out=1, duty_out=0, dir_out=0, state IDLE.
